// File: rtl/seq_shift_add_multiplier_if.sv
// Issue-side bundle of the shift-add multiplier: request operands toward the unit,
// status and result back toward the issuer.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  // Handshake: a request is taken at a rising edge where start=1 and ready=1.
  // Operands and signed_mode matter only at that edge. done pulses for one cycle
  // when product is updated, and product then holds until the next done.
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start,
    output signed_mode,
    output a_in,
    output b_in,
    input  ready,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  signed_mode,
    input  a_in,
    input  b_in,
    output ready,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier (unsigned or two's-complement per operation).
// The multiplier is retired LSB-first and the loop stops once no set bits remain.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_shift_add_multiplier_if.slave   bus,
  output logic [1:0]                  state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   mag_a_q;
  logic [WIDTH-1:0]     mag_b_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     mag_b_d;
  logic                 last_step;

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  always_comb begin
    a_abs = bus.a_in;
    b_abs = bus.b_in;
    if (bus.signed_mode && bus.a_in[WIDTH-1]) a_abs = -bus.a_in;
    if (bus.signed_mode && bus.b_in[WIDTH-1]) b_abs = -bus.b_in;
  end

  always_comb begin
    acc_d     = acc_q;
    mag_b_d   = mag_b_q >> 1;
    last_step = 1'b0;
    if (mag_b_q[0]) acc_d = acc_q + mag_a_q;
    if ((mag_b_d == '0) || (cnt_q == CNT_LAST)) last_step = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mag_a_q <= {{WIDTH{1'b0}}, a_abs};
            mag_b_q <= b_abs;
            neg_q   <= bus.signed_mode & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_ADD;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_ADD: begin
          acc_q   <= acc_d;
          mag_a_q <= mag_a_q << 1;
          mag_b_q <= mag_b_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_step) begin
            product_q <= neg_q ? -acc_d : acc_d;
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign state_o     = state_q;

endmodule
